rank_div_fx: RTL and testbench
==============================

RANK_DIV_FX -- requirements
Module: rank_div_fx

Interface
- REQ-001 SHALL provide parameter WIDTH, default 32: operand and quotient width in bits.
- REQ-002 SHALL provide parameter FRAC, default 16: fractional bits in the fixed-point quotient.
- REQ-003 SHALL provide port clk, input, 1: clock, rising-edge active.
- REQ-004 SHALL provide port reset, input, 1: reset, asynchronous, active-low.
- REQ-005 SHALL provide port flush, input, 1: synchronous abort.
- REQ-006 SHALL provide port in_valid, input, 1: operands present.
- REQ-007 SHALL provide port in_ready, output, 1: block can accept operands.
- REQ-008 SHALL provide port page_rank, input, WIDTH: dividend, unsigned.
- REQ-009 SHALL provide port out_deg, input, WIDTH: divisor, unsigned.
- REQ-010 SHALL provide port out_valid, output, 1: result present.
- REQ-011 SHALL provide port out_ready, input, 1: consumer accepts result.
- REQ-012 SHALL provide port quotient, output, WIDTH: fixed-point result, FRAC fraction bits.
- REQ-013 SHALL provide port dbz, output, 1: divide-by-zero flag for the current result.
- REQ-014 SHALL provide port ovf, output, 1: quotient overflow flag for the current result.

Function
- REQ-015 SHALL compute Q = floor((page_rank << FRAC) / out_deg) over N = WIDTH+FRAC bits.
- REQ-016 SHALL use restoring shift-subtract division, one quotient bit per clock; no divider operator, no multi-cycle paths.
- REQ-017 SHALL drive quotient with Q[WIDTH-1:0] and ovf=1 when Q[N-1:WIDTH] is nonzero.
- REQ-018 SHALL implement states IDLE, CALC and DONE.
- REQ-019 IDLE SHALL drive in_ready=1 and out_valid=0.
- REQ-020 In IDLE, a rising edge with in_valid=1 SHALL capture both operands.
- REQ-021 On capture with out_deg nonzero, the block SHALL clear the remainder and iteration counter and move to CALC.
- REQ-022 On capture with out_deg=0, the block SHALL move straight to DONE with quotient all-ones, dbz=1 and ovf=0.
- REQ-023 CALC SHALL drive in_ready=0 and perform exactly N iterations, one per edge.
- REQ-024 The edge carrying iteration N SHALL load the result and move to DONE.
- REQ-025 Latency SHALL be: out_valid rises N edges after the capture edge, or 1 edge after it for divide-by-zero.
- REQ-026 DONE SHALL drive out_valid=1 and in_ready=0.
- REQ-027 quotient, dbz and ovf SHALL stay stable while out_valid=1 and out_ready=0.
- REQ-028 In DONE, an edge with out_ready=1 SHALL return the block to IDLE.
- REQ-029 No new operands SHALL be accepted on the edge that returns DONE to IDLE; back-to-back throughput is one result per N+2 cycles.
- REQ-030 flush=1 at any edge SHALL force IDLE, discard any in-flight or pending result and leave outputs at reset values.
- REQ-031 flush SHALL take priority over in_valid and out_ready on the same edge.
- REQ-032 Changes on page_rank and out_deg after capture SHALL NOT affect the result.
- REQ-033 out_deg=1 SHALL give Q = page_rank << FRAC, with ovf set when any of the top FRAC bits of page_rank is nonzero.
- REQ-034 page_rank=0 with nonzero out_deg SHALL give quotient=0, dbz=0 and ovf=0.

Reset
- REQ-035 reset low SHALL immediately force state IDLE.
- REQ-036 reset low SHALL immediately force in_ready=1, out_valid=0, quotient=0, dbz=0 and ovf=0.
- REQ-037 reset low SHALL immediately clear the internal remainder, quotient register and counter.
- REQ-038 Asserting reset mid-CALC or in DONE SHALL drop the operation, and the block SHALL produce no out_valid for it.
- REQ-039 After reset release, the first rising edge SHALL be able to accept operands.

Verification (WIDTH=32, FRAC=16)
- REQ-040 Stimulus page_rank=100, out_deg=4 SHALL produce quotient=0x0019_0000, dbz=0, ovf=0, with out_valid 48 edges after capture.
- REQ-041 Stimulus page_rank=1, out_deg=3 SHALL produce quotient=0x0000_5555 (truncated) with ovf=0.
- REQ-042 Stimulus page_rank=7, out_deg=0 SHALL produce quotient=0xFFFF_FFFF, dbz=1, with out_valid 1 edge after capture.
- REQ-043 Stimulus page_rank=0x0001_0000, out_deg=1 SHALL produce quotient=0x0000_0000 and ovf=1.
- REQ-044 Holding out_ready=0 for 10 cycles in DONE SHALL keep out_valid and quotient stable and in_ready=0; the return to IDLE SHALL follow the out_ready=1 edge.
- REQ-045 Pulsing reset low (and separately flush high) at iteration 20 of 48 SHALL give IDLE on the next edge with no out_valid; a following 9/3 SHALL yield 0x0003_0000.

Source files
------------

// File: rtl/rank_div_fx.sv
// Fixed-point divider: quotient = floor((page_rank << FRAC) / out_deg), one quotient bit per clock.
// Latency WIDTH+FRAC edges after capture (1 edge for divide-by-zero); result holds in DONE until out_ready.
module rank_div_fx #(
    parameter int WIDTH = 32,
    parameter int FRAC  = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] page_rank,
    input  logic [WIDTH-1:0] out_deg,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic             dbz,
    output logic             ovf
);
    localparam int N  = WIDTH + FRAC;
    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t           state_q;
    logic [WIDTH-1:0] div_q;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [N-1:0]     dvd_q, dvd_d;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH:0]   trial;
    logic             qbit;

    logic             in_ready_q;
    logic             out_valid_q;
    logic [WIDTH-1:0] quotient_q;
    logic             dbz_q;
    logic             ovf_q;

    // The dividend register shifts out dividend bits at the top and collects
    // quotient bits at the bottom, so after N steps it holds the full quotient.
    always_comb begin
        trial = {rem_q, dvd_q[N-1]};
        qbit  = (trial >= {1'b0, div_q});
        rem_d = qbit ? WIDTH'(trial - {1'b0, div_q}) : trial[WIDTH-1:0];
        dvd_d = {dvd_q[N-2:0], qbit};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            div_q       <= '0;
            rem_q       <= '0;
            dvd_q       <= '0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            quotient_q  <= '0;
            dbz_q       <= 1'b0;
            ovf_q       <= 1'b0;
        end else if (flush) begin
            state_q     <= IDLE;
            rem_q       <= '0;
            dvd_q       <= '0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            quotient_q  <= '0;
            dbz_q       <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        div_q      <= out_deg;
                        dvd_q      <= {page_rank, {FRAC{1'b0}}};
                        rem_q      <= '0;
                        cnt_q      <= '0;
                        in_ready_q <= 1'b0;
                        if (out_deg == '0) begin
                            state_q     <= DONE;
                            out_valid_q <= 1'b1;
                            quotient_q  <= '1;
                            dbz_q       <= 1'b1;
                            ovf_q       <= 1'b0;
                        end else begin
                            state_q <= CALC;
                        end
                    end
                end
                CALC: begin
                    rem_q <= rem_d;
                    dvd_q <= dvd_d;
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == CW'(N - 1)) begin
                        state_q     <= DONE;
                        out_valid_q <= 1'b1;
                        quotient_q  <= dvd_d[WIDTH-1:0];
                        dbz_q       <= 1'b0;
                        ovf_q       <= |dvd_d[N-1:WIDTH];
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign quotient  = quotient_q;
    assign dbz       = dbz_q;
    assign ovf       = ovf_q;
endmodule

// File: tb/tb_rank_div_fx.sv
// Directed vector bench for rank_div_fx with WIDTH=32, FRAC=16.
module tb_rank_div_fx;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] page_rank = '0;
    logic [31:0] out_deg = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] quotient;
    logic        dbz;
    logic        ovf;

    int errors = 0;
    int checks = 0;

    rank_div_fx #(.WIDTH(32), .FRAC(16)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .page_rank(page_rank), .out_deg(out_deg),
        .out_valid(out_valid), .out_ready(out_ready),
        .quotient(quotient), .dbz(dbz), .ovf(ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pr;
        logic [31:0] deg;
        logic [31:0] q;
        logic        dbz;
        logic        ovf;
        int          lat;
    } vec_t;

    vec_t vt[11];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    // Present operands for one edge, then scramble the inputs to show they were latched.
    task automatic start(input logic [31:0] pr, input logic [31:0] deg);
        @(negedge clk);
        page_rank = pr;
        out_deg   = deg;
        in_valid  = 1'b1;
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        page_rank = $urandom;
        out_deg   = $urandom;
        chk("in_ready_after_capture", {31'd0, in_ready}, 32'd0);
    endtask

    task automatic wait_valid(output int lat);
        bit got = 0;
        lat = 0;
        while (!got && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
            if (out_valid) got = 1;
        end
        if (!got) begin
            errors++;
            checks++;
            $display("FAIL wait_valid: out_valid never rose within %0d edges", lat);
        end
    endtask

    task automatic release_result();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("out_valid_after_accept", {31'd0, out_valid}, 32'd0);
        chk("in_ready_after_accept", {31'd0, in_ready}, 32'd1);
    endtask

    task automatic watch_silent(input string nm);
        bit seen = 0;
        repeat (60) begin
            @(posedge clk);
            #1;
            if (out_valid) seen = 1;
        end
        chk(nm, {31'd0, seen}, 32'd0);
    endtask

    task automatic run_93(input string nm);
        int lat;
        start(32'd9, 32'd3);
        wait_valid(lat);
        chk({nm, "_lat"}, lat, 32'd48);
        chk({nm, "_q"}, quotient, 32'h0003_0000);
        release_result();
    endtask

    initial begin
        int lat;
        int t, t1, t2;

        vt[0]  = '{32'd100,       32'd4,         32'h0019_0000, 1'b0, 1'b0, 48};
        vt[1]  = '{32'd1,         32'd3,         32'h0000_5555, 1'b0, 1'b0, 48};
        vt[2]  = '{32'd7,         32'd0,         32'hFFFF_FFFF, 1'b1, 1'b0, 1};
        vt[3]  = '{32'h0001_0000, 32'd1,         32'h0000_0000, 1'b0, 1'b1, 48};
        vt[4]  = '{32'd0,         32'd5,         32'h0000_0000, 1'b0, 1'b0, 48};
        vt[5]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0001_0000, 1'b0, 1'b0, 48};
        vt[6]  = '{32'd9,         32'd3,         32'h0003_0000, 1'b0, 1'b0, 48};
        vt[7]  = '{32'h0000_FFFF, 32'd1,         32'hFFFF_0000, 1'b0, 1'b0, 48};
        vt[8]  = '{32'd5,         32'd2,         32'h0002_8000, 1'b0, 1'b0, 48};
        vt[9]  = '{32'd1,         32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1'b0, 48};
        vt[10] = '{32'hFFFF_FFFF, 32'd2,         32'hFFFF_8000, 1'b0, 1'b1, 48};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_quotient", quotient, 32'd0);
        chk("rst_dbz", {31'd0, dbz}, 32'd0);
        chk("rst_ovf", {31'd0, ovf}, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 11; i++) begin
            start(vt[i].pr, vt[i].deg);
            wait_valid(lat);
            chk($sformatf("v%0d_lat", i), lat, vt[i].lat);
            chk($sformatf("v%0d_q", i), quotient, vt[i].q);
            chk($sformatf("v%0d_dbz", i), {31'd0, dbz}, {31'd0, vt[i].dbz});
            chk($sformatf("v%0d_ovf", i), {31'd0, ovf}, {31'd0, vt[i].ovf});
            chk($sformatf("v%0d_in_ready_done", i), {31'd0, in_ready}, 32'd0);
            release_result();
        end

        // Stall in DONE for 10 cycles.
        start(32'd100, 32'd4);
        wait_valid(lat);
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            chk($sformatf("stall%0d_valid", c), {31'd0, out_valid}, 32'd1);
            chk($sformatf("stall%0d_q", c), quotient, 32'h0019_0000);
            chk($sformatf("stall%0d_in_ready", c), {31'd0, in_ready}, 32'd0);
        end
        release_result();

        // Async reset mid-calculation.
        start(32'd100, 32'd4);
        repeat (20) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("arst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("arst_quotient", quotient, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        watch_silent("arst_no_valid");
        run_93("after_arst");

        // Flush mid-calculation.
        start(32'd100, 32'd4);
        repeat (20) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        chk("flush_in_ready", {31'd0, in_ready}, 32'd1);
        chk("flush_out_valid", {31'd0, out_valid}, 32'd0);
        watch_silent("flush_no_valid");
        run_93("after_flush");

        // Flush wins over a pending result and over out_ready.
        start(32'd7, 32'd0);
        wait_valid(lat);
        @(negedge clk);
        flush = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        out_ready = 1'b0;
        chk("flush_done_valid", {31'd0, out_valid}, 32'd0);
        chk("flush_done_q", quotient, 32'd0);
        chk("flush_done_dbz", {31'd0, dbz}, 32'd0);
        chk("flush_done_in_ready", {31'd0, in_ready}, 32'd1);

        // Flush wins over in_valid in IDLE.
        @(negedge clk);
        flush = 1'b1;
        in_valid = 1'b1;
        page_rank = 32'd5;
        out_deg = 32'd1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        in_valid = 1'b0;
        chk("flush_vs_in_valid", {31'd0, in_ready}, 32'd1);
        watch_silent("flush_vs_in_valid_silent");

        // Back-to-back throughput with in_valid and out_ready held high.
        @(negedge clk);
        page_rank = 32'd9;
        out_deg = 32'd3;
        in_valid = 1'b1;
        out_ready = 1'b1;
        t = 0;
        t1 = -1;
        t2 = -1;
        while (t2 < 0 && t < 300) begin
            @(posedge clk);
            #1;
            t++;
            if (out_valid) begin
                if (t1 < 0) t1 = t;
                else t2 = t;
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b0;
        chk("throughput_spacing", t2 - t1, 32'd50);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
